// File: rtl/multicycle_control_if.sv
// multicycle_control_if: controller <-> datapath bundle; the controller is the master.
interface multicycle_control_if #(parameter int ALUFUN_W = 6);
  logic [31:0]         instruct;
  logic                IRQsig;
  logic                super_mode;
  logic                mem_ready;
  logic                PCWr;
  logic                IRWr;
  logic [2:0]          PCsrc;
  logic [1:0]          RegDst;
  logic [1:0]          MemtoReg;
  logic [ALUFUN_W-1:0] ALUFun;
  logic                Sign;
  logic                ALUsrc1;
  logic                ALUsrc2;
  logic                RegWr;
  logic                MemWr;
  logic                MemRd;
  logic                EXTOp;
  logic                LUOp;
  logic [2:0]          state;
  modport master (
    input  instruct, IRQsig, super_mode, mem_ready,
    output PCWr, IRWr, PCsrc, RegDst, MemtoReg, ALUFun, Sign, ALUsrc1, ALUsrc2,
           RegWr, MemWr, MemRd, EXTOp, LUOp, state
  );
  modport slave (
    output instruct, IRQsig, super_mode, mem_ready,
    input  PCWr, IRWr, PCsrc, RegDst, MemtoReg, ALUFun, Sign, ALUsrc1, ALUsrc2,
           RegWr, MemWr, MemRd, EXTOp, LUOp, state
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB/TRAP controller with IRQ, illegal-op and memory-timeout traps.
module multicycle_control #(
  parameter int ALUFUN_W    = 6,
  parameter int MEM_TIMEOUT = 16,
  parameter bit IRQ_EN      = 1'b1
) (
  input logic clk,
  input logic reset,
  multicycle_control_if.master bus
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  typedef enum logic [2:0] {K_ALU, K_BR, K_J, K_JR, K_JAL, K_JALR, K_LW, K_SW} kind_t;
  localparam int CW = $clog2(MEM_TIMEOUT + 2);
  state_t        r_state;
  state_t        w_next;
  logic          r_cause;
  logic [CW-1:0] r_cnt;
  logic [5:0]    w_op;
  logic [5:0]    w_fn;
  logic [5:0]    w_fun;
  logic          w_legal;
  logic          w_sign;
  logic          w_ext;
  logic          w_src1;
  logic          w_src2;
  logic          w_lu;
  logic          w_irq;
  logic          w_to;
  logic          w_link;
  logic          w_unused;
  kind_t         w_kind;
  assign w_op     = bus.instruct[31:26];
  assign w_fn     = bus.instruct[5:0];
  assign w_unused = &{1'b0, bus.instruct[25:21], bus.instruct[15:6]};
  assign w_irq    = IRQ_EN && bus.IRQsig && !bus.super_mode;
  assign w_to     = (MEM_TIMEOUT != 0) && (r_cnt + CW'(1) == CW'(MEM_TIMEOUT));
  assign w_link   = (w_kind == K_JAL) || (w_kind == K_JALR);
  assign bus.state = r_state;
  always_comb begin
    w_legal = 1'b1;
    w_fun   = 6'b000000;
    w_sign  = 1'b0;
    w_ext   = 1'b0;
    w_src1  = 1'b0;
    w_src2  = 1'b0;
    w_lu    = 1'b0;
    w_kind  = K_ALU;
    if (w_op == 6'h00)
      case (w_fn)
        6'h20: w_sign = 1'b1;
        6'h21: ;
        6'h22: begin w_fun = 6'b000001; w_sign = 1'b1; end
        6'h23: w_fun = 6'b000001;
        6'h24: w_fun = 6'b011000;
        6'h25: w_fun = 6'b011110;
        6'h26: w_fun = 6'b010110;
        6'h27: w_fun = 6'b010001;
        6'h2a: begin w_fun = 6'b110101; w_sign = 1'b1; end
        6'h00: begin w_fun = 6'b100000; w_src1 = 1'b1; end
        6'h02: begin w_fun = 6'b100001; w_src1 = 1'b1; end
        6'h03: begin w_fun = 6'b100011; w_src1 = 1'b1; end
        6'h08: w_kind = K_JR;
        6'h09: w_kind = K_JALR;
        default: w_legal = 1'b0;
      endcase
    else
      case (w_op)
        6'h08: begin w_sign = 1'b1; w_ext = 1'b1; w_src2 = 1'b1; end
        6'h09: w_src2 = 1'b1;
        6'h0a: begin w_fun = 6'b110101; w_sign = 1'b1; w_ext = 1'b1; w_src2 = 1'b1; end
        6'h0b: begin w_fun = 6'b110101; w_src2 = 1'b1; end
        6'h0c: begin w_fun = 6'b011000; w_ext = 1'b1; w_src2 = 1'b1; end
        6'h0f: begin w_fun = 6'b011010; w_src2 = 1'b1; w_lu = 1'b1; end
        6'h04: begin w_fun = 6'b110011; w_sign = 1'b1; w_ext = 1'b1; w_kind = K_BR; end
        6'h05: begin w_fun = 6'b110001; w_sign = 1'b1; w_ext = 1'b1; w_kind = K_BR; end
        6'h06: begin w_fun = 6'b111101; w_sign = 1'b1; w_ext = 1'b1; w_kind = K_BR; end
        6'h07: begin w_fun = 6'b111111; w_sign = 1'b1; w_ext = 1'b1; w_kind = K_BR; end
        // opcode 1 is REGIMM: only rt=0 (bltz) is implemented
        6'h01: begin
          w_fun   = 6'b111001;
          w_sign  = 1'b1;
          w_ext   = 1'b1;
          w_kind  = K_BR;
          w_legal = bus.instruct[20:16] == 5'd0;
        end
        6'h23: begin w_sign = 1'b1; w_ext = 1'b1; w_kind = K_LW; end
        6'h2b: begin w_sign = 1'b1; w_ext = 1'b1; w_kind = K_SW; end
        6'h02: w_kind = K_J;
        6'h03: w_kind = K_JAL;
        default: w_legal = 1'b0;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_cause <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == TRAP) r_cause <= !(r_state == DECODE && w_irq);
      r_cnt <= (r_state == MEM && !bus.mem_ready) ? r_cnt + CW'(1) : '0;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:   w_next = DECODE;
      DECODE:  w_next = (w_irq || !w_legal) ? TRAP : EXEC;
      EXEC:    w_next = (w_kind == K_LW || w_kind == K_SW) ? MEM : (w_kind == K_ALU) ? WB : FETCH;
      MEM:     w_next = bus.mem_ready ? ((w_kind == K_LW) ? WB : FETCH) : w_to ? TRAP : MEM;
      default: w_next = FETCH;
    endcase
  end
  always_comb begin
    bus.PCWr     = 1'b0;
    bus.IRWr     = 1'b0;
    bus.PCsrc    = 3'd0;
    bus.RegDst   = 2'd0;
    bus.MemtoReg = 2'd0;
    bus.ALUFun   = '0;
    bus.Sign     = 1'b0;
    bus.ALUsrc1  = 1'b0;
    bus.ALUsrc2  = 1'b0;
    bus.RegWr    = 1'b0;
    bus.MemWr    = 1'b0;
    bus.MemRd    = 1'b0;
    bus.EXTOp    = 1'b0;
    bus.LUOp     = 1'b0;
    case (r_state)
      FETCH: bus.IRWr = 1'b1;
      EXEC: begin
        bus.ALUFun   = ALUFUN_W'(w_fun);
        bus.Sign     = w_sign;
        bus.EXTOp    = w_ext;
        bus.ALUsrc1  = w_src1;
        bus.ALUsrc2  = w_src2;
        bus.LUOp     = w_lu;
        bus.PCWr     = !(w_kind == K_ALU || w_kind == K_LW || w_kind == K_SW);
        bus.PCsrc    = (w_kind == K_BR) ? 3'd1 : (w_kind == K_J || w_kind == K_JAL) ? 3'd2 :
                       (w_kind == K_JR || w_kind == K_JALR) ? 3'd3 : 3'd0;
        bus.RegWr    = w_link;
        bus.RegDst   = w_link ? 2'd2 : 2'd0;
        bus.MemtoReg = w_link ? 2'd2 : 2'd0;
      end
      MEM: begin
        bus.MemRd = w_kind == K_LW;
        bus.MemWr = w_kind == K_SW;
        bus.PCWr  = (w_kind == K_SW) && bus.mem_ready;
      end
      WB: begin
        bus.RegWr    = 1'b1;
        bus.PCWr     = 1'b1;
        bus.RegDst   = {1'b0, w_op != 6'h00};
        bus.MemtoReg = {1'b0, w_kind == K_LW};
      end
      TRAP: begin
        bus.RegWr    = 1'b1;
        bus.RegDst   = 2'd3;
        bus.MemtoReg = 2'd2;
        bus.PCWr     = 1'b1;
        bus.PCsrc    = r_cause ? 3'd5 : 3'd4;
      end
      default: ;
    endcase
    // an instruction cut off by reset must not commit anything in its last cycle
    if (reset) begin
      bus.PCWr  = 1'b0;
      bus.RegWr = 1'b0;
      bus.MemWr = 1'b0;
      bus.MemRd = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random instruction streams against a table-driven model; a negedge monitor scores each cycle.
module tb_multicycle_control;
  typedef struct packed {
    logic [2:0] st;
    logic       pcwr, irwr;
    logic [2:0] pcsrc;
    logic [1:0] regdst, memtoreg;
    logic [5:0] fun;
    logic       sign, s1, s2, regwr, memwr, memrd, ext, lu;
  } ov_t;
  typedef struct packed {
    logic [5:0] op, fn, fun;
    logic       sign, ext, s1, s2, lu;
    logic [3:0] cls;
  } ent_t;
  localparam logic [3:0] C_R = 0, C_I = 1, C_BR = 2, C_J = 3, C_JR = 4, C_JAL = 5, C_JALR = 6, C_LW = 7, C_SW = 8;
  logic clk = 1'b0;
  logic rst0, rst1;
  logic [31:0] instr;
  logic irq, sup, mr;
  bit phase = 1'b0;
  bit irq_en = 1'b1;
  int to_lim = 16;
  int checks = 0;
  int errors = 0;
  ent_t tbl[$];
  ov_t exp_q[$];
  string tag_q[$];
  ov_t a0, a1, act, ex;
  string tg;
  always #5 clk = ~clk;
  multicycle_control_if #(.ALUFUN_W(6)) b0();
  multicycle_control_if #(.ALUFUN_W(6)) b1();
  multicycle_control u0 (.clk(clk), .reset(rst0), .bus(b0.master));
  multicycle_control #(.IRQ_EN(1'b0), .MEM_TIMEOUT(0)) u1 (.clk(clk), .reset(rst1), .bus(b1.master));
  assign b0.instruct = instr;
  assign b0.IRQsig = irq;
  assign b0.super_mode = sup;
  assign b0.mem_ready = mr;
  assign b1.instruct = instr;
  assign b1.IRQsig = irq;
  assign b1.super_mode = sup;
  assign b1.mem_ready = mr;
  assign a0 = {b0.state, b0.PCWr, b0.IRWr, b0.PCsrc, b0.RegDst, b0.MemtoReg, b0.ALUFun,
               b0.Sign, b0.ALUsrc1, b0.ALUsrc2, b0.RegWr, b0.MemWr, b0.MemRd, b0.EXTOp, b0.LUOp};
  assign a1 = {b1.state, b1.PCWr, b1.IRWr, b1.PCsrc, b1.RegDst, b1.MemtoReg, b1.ALUFun,
               b1.Sign, b1.ALUsrc1, b1.ALUsrc2, b1.RegWr, b1.MemWr, b1.MemRd, b1.EXTOp, b1.LUOp};
  always @(negedge clk)
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      tg = tag_q.pop_front();
      act = phase ? a1 : a0;
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL %s @%0t: dut=%h (state %0d) expected=%h (state %0d)", tg, $time, act, act.st, ex, ex.st);
      end
    end
  task automatic add(input logic [5:0] op, fn, fun, input bit sign, ext, s1, s2, lu, input logic [3:0] cls);
    tbl.push_back(ent_t'({op, fn, fun, sign, ext, s1, s2, lu, cls}));
  endtask
  function automatic int lookup(input logic [31:0] w);
    foreach (tbl[i])
      if (tbl[i].op == w[31:26] && (w[31:26] != 6'h00 || tbl[i].fn == w[5:0]) &&
          (w[31:26] != 6'h01 || w[20:16] == 5'd0)) return i;
    return -1;
  endfunction
  function automatic logic [31:0] word_rand();
    logic [31:0] w = $urandom;
    ent_t e;
    if ($urandom_range(0, 4) == 0) return w;
    e = tbl[$urandom_range(0, tbl.size() - 1)];
    w[31:26] = e.op;
    if (e.op == 6'h00) w[5:0] = e.fn;
    if (e.op == 6'h01) w[20:16] = 5'd0;
    return w;
  endfunction
  function automatic ov_t st_only(input int s);
    ov_t o = '0;
    o.st = 3'(s);
    return o;
  endfunction
  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic step(input ov_t v, input string tag, input logic i_irq, i_sup, i_mr);
    irq = i_irq;
    sup = i_sup;
    mr = i_mr;
    exp_q.push_back(v);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask
  task automatic trap(input bit exc);
    ov_t o = st_only(5);
    o.regwr = 1'b1;
    o.regdst = 2'd3;
    o.memtoreg = 2'd2;
    o.pcwr = 1'b1;
    o.pcsrc = exc ? 3'd5 : 3'd4;
    step(o, exc ? "trap_exc" : "trap_irq", rb(), rb(), rb());
  endtask
  task automatic run(input logic [31:0] w, input logic d_irq, d_sup, input int dly, input bit rst_mem);
    ov_t o;
    ent_t e;
    int idx;
    bit rdy;
    instr = w;
    idx = lookup(w);
    o = st_only(0);
    o.irwr = 1'b1;
    step(o, "fetch", rb(), rb(), rb());
    step(st_only(1), "decode", d_irq, d_sup, rb());
    if (irq_en && d_irq && !d_sup) begin trap(1'b0); return; end
    if (idx < 0) begin trap(1'b1); return; end
    e = tbl[idx];
    o = st_only(2);
    o.fun = e.fun;
    o.sign = e.sign;
    o.ext = e.ext;
    o.s1 = e.s1;
    o.s2 = e.s2;
    o.lu = e.lu;
    o.pcwr = e.cls inside {C_BR, C_J, C_JR, C_JAL, C_JALR};
    o.pcsrc = (e.cls == C_BR) ? 3'd1 : (e.cls inside {C_J, C_JAL}) ? 3'd2 : (e.cls inside {C_JR, C_JALR}) ? 3'd3 : 3'd0;
    o.regwr = e.cls inside {C_JAL, C_JALR};
    o.regdst = o.regwr ? 2'd2 : 2'd0;
    o.memtoreg = o.regwr ? 2'd2 : 2'd0;
    step(o, "exec", rb(), rb(), rb());
    if (o.pcwr) return;
    if (e.cls inside {C_LW, C_SW})
      for (int k = 0; ; k++) begin
        if (rst_mem && k == 1) begin
          mr = 1'b0;
          if (phase) rst1 = 1'b1; else rst0 = 1'b1;
          @(posedge clk);
          #1;
          if (phase) rst1 = 1'b0; else rst0 = 1'b0;
          return;
        end
        rdy = (k == dly);
        o = st_only(3);
        o.memrd = e.cls == C_LW;
        o.memwr = e.cls == C_SW;
        o.pcwr = (e.cls == C_SW) && rdy;
        step(o, "mem", rb(), rb(), rdy);
        if (rdy && e.cls == C_SW) return;
        if (rdy) break;
        if (to_lim > 0 && k + 1 == to_lim) begin trap(1'b1); return; end
      end
    o = st_only(4);
    o.regwr = 1'b1;
    o.pcwr = 1'b1;
    o.regdst = (e.op == 6'h00) ? 2'd0 : 2'd1;
    o.memtoreg = (e.cls == C_LW) ? 2'd1 : 2'd0;
    step(o, "wb", rb(), rb(), rb());
  endtask
  function automatic int dly_rand();
    int pick = $urandom_range(0, 9);
    return pick < 6 ? pick : pick == 6 ? 15 : pick == 7 ? 16 : 25;
  endfunction
  initial begin
    add(6'h00, 6'h20, 6'b000000, 1, 0, 0, 0, 0, C_R);
    add(6'h00, 6'h21, 6'b000000, 0, 0, 0, 0, 0, C_R);
    add(6'h00, 6'h22, 6'b000001, 1, 0, 0, 0, 0, C_R);
    add(6'h00, 6'h23, 6'b000001, 0, 0, 0, 0, 0, C_R);
    add(6'h00, 6'h24, 6'b011000, 0, 0, 0, 0, 0, C_R);
    add(6'h00, 6'h25, 6'b011110, 0, 0, 0, 0, 0, C_R);
    add(6'h00, 6'h26, 6'b010110, 0, 0, 0, 0, 0, C_R);
    add(6'h00, 6'h27, 6'b010001, 0, 0, 0, 0, 0, C_R);
    add(6'h00, 6'h2a, 6'b110101, 1, 0, 0, 0, 0, C_R);
    add(6'h00, 6'h00, 6'b100000, 0, 0, 1, 0, 0, C_R);
    add(6'h00, 6'h02, 6'b100001, 0, 0, 1, 0, 0, C_R);
    add(6'h00, 6'h03, 6'b100011, 0, 0, 1, 0, 0, C_R);
    add(6'h00, 6'h08, 6'b000000, 0, 0, 0, 0, 0, C_JR);
    add(6'h00, 6'h09, 6'b000000, 0, 0, 0, 0, 0, C_JALR);
    add(6'h08, 6'h00, 6'b000000, 1, 1, 0, 1, 0, C_I);
    add(6'h09, 6'h00, 6'b000000, 0, 0, 0, 1, 0, C_I);
    add(6'h0a, 6'h00, 6'b110101, 1, 1, 0, 1, 0, C_I);
    add(6'h0b, 6'h00, 6'b110101, 0, 0, 0, 1, 0, C_I);
    add(6'h0c, 6'h00, 6'b011000, 0, 1, 0, 1, 0, C_I);
    add(6'h0f, 6'h00, 6'b011010, 0, 0, 0, 1, 1, C_I);
    add(6'h04, 6'h00, 6'b110011, 1, 1, 0, 0, 0, C_BR);
    add(6'h05, 6'h00, 6'b110001, 1, 1, 0, 0, 0, C_BR);
    add(6'h06, 6'h00, 6'b111101, 1, 1, 0, 0, 0, C_BR);
    add(6'h07, 6'h00, 6'b111111, 1, 1, 0, 0, 0, C_BR);
    add(6'h01, 6'h00, 6'b111001, 1, 1, 0, 0, 0, C_BR);
    add(6'h23, 6'h00, 6'b000000, 1, 1, 0, 0, 0, C_LW);
    add(6'h2b, 6'h00, 6'b000000, 1, 1, 0, 0, 0, C_SW);
    add(6'h02, 6'h00, 6'b000000, 0, 0, 0, 0, 0, C_J);
    add(6'h03, 6'h00, 6'b000000, 0, 0, 0, 0, 0, C_JAL);
    rst0 = 1'b1;
    rst1 = 1'b1;
    instr = '0;
    irq = 1'b0;
    sup = 1'b0;
    mr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0;
    run({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 0, 0, 0, 0);
    run({6'h23, 5'd1, 5'd2, 16'h0010}, 0, 0, 3, 0);
    run({6'h2b, 5'd1, 5'd2, 16'h0010}, 0, 0, 100, 0);
    run({6'h04, 5'd1, 5'd2, 16'h0004}, 1, 0, 0, 0);
    run({6'h04, 5'd1, 5'd2, 16'h0004}, 1, 1, 0, 0);
    run({6'h3f, 26'h0}, 0, 0, 0, 0);
    run({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h01}, 0, 0, 0, 0);
    run({6'h01, 5'd1, 5'd1, 16'h0004}, 0, 0, 0, 0);
    run({6'h3f, 26'h0}, 1, 0, 0, 0);
    run({6'h2b, 5'd1, 5'd2, 16'h0010}, 0, 0, 10, 1);
    run({6'h23, 5'd1, 5'd2, 16'h0010}, 0, 0, 10, 1);
    run({6'h23, 5'd1, 5'd2, 16'h0010}, 0, 0, 15, 0);
    run({6'h23, 5'd1, 5'd2, 16'h0010}, 0, 0, 16, 0);
    for (int n = 0; n < 150; n++)
      run(word_rand(), $urandom_range(0, 3) == 0, rb(), dly_rand(), $urandom_range(0, 19) == 0);
    rst0 = 1'b1;
    rst1 = 1'b0;
    phase = 1'b1;
    irq_en = 1'b0;
    to_lim = 0;
    run({6'h04, 5'd1, 5'd2, 16'h0004}, 1, 0, 0, 0);
    run({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 1, 0, 0, 0);
    run({6'h2b, 5'd1, 5'd2, 16'h0010}, 1, 0, 25, 0);
    run({6'h3f, 26'h0}, 1, 0, 0, 0);
    for (int n = 0; n < 40; n++)
      run(word_rand(), rb(), rb(), dly_rand(), $urandom_range(0, 19) == 0);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
